// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall and taken-branch flush sequencing for IF, IF/DC and DC/EX.
module hazard_stall_unit #(
  parameter int REG_W        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dc_valid,
  input  logic [REG_W-1:0] dc_rs1,
  input  logic [REG_W-1:0] dc_rs2,
  input  logic             dc_rs1_used,
  input  logic             dc_rs2_used,
  input  logic [REG_W-1:0] dc_rd,
  input  logic             dc_rd_we,
  input  logic             dc_is_load,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             if_dc_we,
  output logic             if_dc_flush,
  output logic             dc_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [1:0] LD_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;
  localparam logic [1:0] FL_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  state_t           r_state, w_next;
  logic [1:0]       r_cnt, w_cnt_next;
  logic             r_ex_valid, r_ex_we, r_ex_load;
  logic [REG_W-1:0] r_ex_rd;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_hz, w_stall, w_flush, w_redirect;
  always_comb begin
    w_hz = dc_valid & r_ex_valid & r_ex_we & r_ex_load &
           ((dc_rs1_used & (dc_rs1 == r_ex_rd)) | (dc_rs2_used & (dc_rs2 == r_ex_rd)));
    w_stall    = 1'b0;
    w_flush    = 1'b0;
    w_redirect = 1'b0;
    w_next     = r_state;
    w_cnt_next = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
    case (r_state)
      RUN: begin
        // A taken branch squashes the decode instruction, so its hazard is moot
        if (ex_branch_taken) begin
          w_flush    = 1'b1;
          w_redirect = 1'b1;
          w_next     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          w_cnt_next = FL_INIT;
        end else if (w_hz) begin
          w_stall    = 1'b1;
          w_next     = (LOAD_LAT > 1) ? STALL : RUN;
          w_cnt_next = LD_INIT;
        end
      end
      STALL: begin
        w_stall = 1'b1;
        w_next  = (r_cnt == 2'd0) ? RUN : STALL;
      end
      FLUSH: begin
        w_flush = 1'b1;
        w_next  = (r_cnt == 2'd0) ? RUN : FLUSH;
      end
      default: w_next = RUN;
    endcase
  end
  assign pc_we        = ~w_stall;
  assign if_dc_we     = ~w_stall;
  assign if_dc_flush  = w_flush;
  assign dc_ex_bubble = w_stall | w_flush;
  assign state        = r_state;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= 2'd0;
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_ex_valid <= dc_valid & ~dc_ex_bubble;
      r_ex_we    <= dc_rd_we;
      r_ex_load  <= dc_is_load;
      r_ex_rd    <= dc_rd;
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule
